// File: rtl/fpadd_pipe_param.sv
// fpadd_pipe_param: multicycle IEEE-754 binary adder/subtractor with start/done handshake.
// States IDLE -> UNPACK -> ALIGN -> ADD -> NORM -> ROUND, one cycle each; done pulses
// five edges after the accepting edge. A one-cycle done pulse also blocks a start in that cycle.
// Build option: define FPADD_DENORM_EN for gradual underflow; otherwise subnormals flush to zero.
module fpadd_pipe_param #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     start,
   input  logic                     op,
   input  logic [EXP_W+MAN_W:0]     a,
   input  logic [EXP_W+MAN_W:0]     b,
   output logic [EXP_W+MAN_W:0]     sum,
   output logic                     done,
   output logic                     busy,
   output logic [3:0]               flags
);

   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int EW = EXP_W + 2;   // internal exponent width
   localparam int MW = MAN_W + 4;   // aligned mantissa 1.f,G,R,S

   localparam logic [EW-1:0] EMAX = {2'b00, {EXP_W{1'b1}}};
   localparam logic [W-1:0]  QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND} state_t;
   state_t state, state_nx;

   logic accept;

   // captured operands (b already sign-adjusted for op)
   logic [W-1:0]     a_r, b_r;
   // unpacked operands and special-case result
   logic             sa_r, sb_r;
   logic [EW-1:0]    ea_r, eb_r;
   logic [MAN_W:0]   ma_r, mb_r;
   logic             sp_r;
   logic [W-1:0]     sp_sum_r;
   logic [3:0]       sp_flags_r;
   // aligned / summed / normalised datapath
   logic             sg_r, sub_r;
   logic [EW-1:0]    ex_r, en_r;
   logic [MW-1:0]    mx_r, my_r, mn_r;
   logic [MW:0]      ms_r;

   // UNPACK combinational
   logic [EXP_W-1:0] ea_f, eb_f;
   logic [MAN_W-1:0] fa, fb;
   logic             nan_a, nan_b, inf_a, inf_b, za, zb;
   logic             u_sp;
   logic [W-1:0]     u_sp_sum;
   logic [3:0]       u_sp_flags;

   // ALIGN combinational
   logic             a_big;
   logic [EW-1:0]    e_big, e_sml, diff;
   logic [MAN_W:0]   m_big, m_sml;
   logic [MW-1:0]    ext, al_my;

   // NORM combinational
   logic [EW-1:0]    lz, lim, sh, nm_en;
   logic [MW-1:0]    nm_mn;
   logic             found;

   // ROUND combinational
   logic             rup, inx, hid;
   logic [MAN_W+1:0] mr;
   logic [MAN_W-1:0] rd_frac;
   logic [EW-1:0]    er;
   logic [W-1:0]     rd_sum;
   logic [3:0]       rd_flags;

   assign accept = (state == S_IDLE) && start && !done;
   assign busy   = (state != S_IDLE) || done;

   // state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nx;
   end

   // next-state sequencing: fixed walk through the stages
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   if (accept) state_nx = S_UNPACK;
         S_UNPACK: state_nx = S_ALIGN;
         S_ALIGN:  state_nx = S_ADD;
         S_ADD:    state_nx = S_NORM;
         S_NORM:   state_nx = S_ROUND;
         S_ROUND:  state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   // field split, classification and special-value result
   always_comb begin
      ea_f  = a_r[W-2:MAN_W];
      eb_f  = b_r[W-2:MAN_W];
      fa    = a_r[MAN_W-1:0];
      fb    = b_r[MAN_W-1:0];
      nan_a = (&ea_f) && (|fa);
      nan_b = (&eb_f) && (|fb);
      inf_a = (&ea_f) && !(|fa);
      inf_b = (&eb_f) && !(|fb);
`ifdef FPADD_DENORM_EN
      za    = (ea_f == '0) && (fa == '0);
      zb    = (eb_f == '0) && (fb == '0);
`else
      za    = (ea_f == '0);
      zb    = (eb_f == '0);
`endif
      u_sp       = 1'b1;
      u_sp_sum   = '0;
      u_sp_flags = '0;
      if (nan_a || nan_b) begin
         u_sp_sum = QNAN;
      end else if (inf_a && inf_b) begin
         if (a_r[W-1] != b_r[W-1]) begin
            u_sp_sum   = QNAN;
            u_sp_flags = 4'b1000;
         end else begin
            u_sp_sum = a_r;
         end
      end else if (inf_a) begin
         u_sp_sum = a_r;
      end else if (inf_b) begin
         u_sp_sum = b_r;
      end else if (za && zb) begin
         u_sp_sum = {a_r[W-1] & b_r[W-1], {(W-1){1'b0}}};
      end else if (za) begin
         u_sp_sum = b_r;
      end else if (zb) begin
         u_sp_sum = a_r;
      end else begin
         u_sp = 1'b0;
      end
   end

   // magnitude swap and right shift with sticky collection
   always_comb begin
      a_big = {ea_r, ma_r} >= {eb_r, mb_r};
      e_big = a_big ? ea_r : eb_r;
      e_sml = a_big ? eb_r : ea_r;
      m_big = a_big ? ma_r : mb_r;
      m_sml = a_big ? mb_r : ma_r;
      diff  = e_big - e_sml;
      ext   = {m_sml, 3'b000};
      // shifts of MW or more leave only the sticky bit, covering the far-out case
      al_my = (ext >> diff) | {{(MW-1){1'b0}}, |(ext & ~({MW{1'b1}} << diff))};
   end

   // leading-zero count and normalisation, exponent floored at 1
   always_comb begin
      lz    = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < MW; i++) begin
         if (!found && ms_r[MW-1-i]) begin
            lz    = EW'(i);
            found = 1'b1;
         end
      end
      lim = ex_r - EW'(1);
      sh  = (lz < lim) ? lz : lim;
      if (ms_r[MW]) begin
         nm_mn = {ms_r[MW:2], ms_r[1] | ms_r[0]};
         nm_en = ex_r + EW'(1);
      end else begin
         nm_mn = ms_r[MW-1:0] << sh;
         nm_en = ex_r - sh;
      end
   end

   // round-to-nearest-even, overflow and tiny-result handling
   always_comb begin
      inx = mn_r[2] | mn_r[1] | mn_r[0];
      rup = mn_r[2] & (mn_r[1] | mn_r[0] | mn_r[3]);
      mr  = {1'b0, mn_r[MW-1:3]} + (MAN_W+2)'(rup);
      if (mr[MAN_W+1]) begin
         er      = en_r + EW'(1);
         rd_frac = mr[MAN_W:1];
         hid     = 1'b1;
      end else begin
         er      = en_r;
         rd_frac = mr[MAN_W-1:0];
         hid     = mr[MAN_W];
      end
      rd_sum   = '0;
      rd_flags = '0;
      if (mn_r == '0) begin
         rd_sum = '0;
      end else if (er >= EMAX) begin
         rd_sum   = {sg_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         rd_flags = 4'b0101;
      end else if (!hid) begin
`ifdef FPADD_DENORM_EN
         rd_sum   = {sg_r, {EXP_W{1'b0}}, rd_frac};
         rd_flags = {2'b00, inx, inx};
`else
         rd_sum   = {sg_r, {(W-1){1'b0}}};
         rd_flags = 4'b0011;
`endif
      end else begin
         rd_sum   = {sg_r, er[EXP_W-1:0], rd_frac};
         rd_flags = {3'b000, inx};
      end
   end

   // datapath registers, one stage loaded per FSM state
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_r <= '0; b_r <= '0;
         sa_r <= 1'b0; sb_r <= 1'b0; ea_r <= '0; eb_r <= '0; ma_r <= '0; mb_r <= '0;
         sp_r <= 1'b0; sp_sum_r <= '0; sp_flags_r <= '0;
         sg_r <= 1'b0; sub_r <= 1'b0; ex_r <= '0; en_r <= '0;
         mx_r <= '0; my_r <= '0; mn_r <= '0; ms_r <= '0;
         sum <= '0; flags <= '0; done <= 1'b0;
      end else begin
         done <= (state == S_ROUND);
         if (accept) begin
            a_r <= a;
            b_r <= {b[W-1] ^ op, b[W-2:0]};
         end
         case (state)
            S_UNPACK: begin
               sa_r       <= a_r[W-1];
               sb_r       <= b_r[W-1];
               ea_r       <= (ea_f == '0) ? EW'(1) : {2'b00, ea_f};
               eb_r       <= (eb_f == '0) ? EW'(1) : {2'b00, eb_f};
               ma_r       <= {|ea_f, fa};
               mb_r       <= {|eb_f, fb};
               sp_r       <= u_sp;
               sp_sum_r   <= u_sp_sum;
               sp_flags_r <= u_sp_flags;
            end
            S_ALIGN: begin
               sg_r  <= a_big ? sa_r : sb_r;
               sub_r <= sa_r ^ sb_r;
               ex_r  <= e_big;
               mx_r  <= {m_big, 3'b000};
               my_r  <= al_my;
            end
            S_ADD: begin
               ms_r <= sub_r ? ({1'b0, mx_r} - {1'b0, my_r}) : ({1'b0, mx_r} + {1'b0, my_r});
            end
            S_NORM: begin
               mn_r <= nm_mn;
               en_r <= nm_en;
            end
            S_ROUND: begin
               sum   <= sp_r ? sp_sum_r : rd_sum;
               flags <= sp_r ? sp_flags_r : rd_flags;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fpadd_pipe_param.sv
// tb_fpadd_pipe_param: directed single-precision checks with an expected-result queue.
// Expected subnormal results depend on FPADD_DENORM_EN.
module tb_fpadd_pipe_param;

   logic        clk, reset_n, start, op;
   logic [31:0] a, b, sum;
   logic        done, busy;
   logic [3:0]  flags;

   typedef struct packed {
      logic [31:0] s;
      logic [3:0]  f;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   t0 = 0;

   fpadd_pipe_param #(.EXP_W(8), .MAN_W(23)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .op(op),
      .a(a), .b(b), .sum(sum), .done(done), .busy(busy), .flags(flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic drive(input logic [31:0] ta, input logic [31:0] tb, input logic top);
      @(negedge clk);
      a = ta; b = tb; op = top; start = 1'b1;
      @(posedge clk);
      #1 t0 = cyc; start = 1'b0;
   endtask

   task automatic launch(input logic [31:0] ta, input logic [31:0] tb, input logic top,
                         input logic [31:0] es, input logic [3:0] ef);
      exp_t e;
      e.s = es; e.f = ef;
      q.push_back(e);
      drive(ta, tb, top);
   endtask

   task automatic wait_done(input string tag);
      int   n;
      logic seen;
      exp_t e;
      n = 0; seen = 1'b0;
      while (n < 20 && !seen) begin
         @(negedge clk);
         if (done === 1'b1) seen = 1'b1;
         else n++;
      end
      checks++;
      assert (seen === 1'b1) else begin
         errors++; $error("FAIL %s_timeout got no done want done", tag);
      end
      if (seen) begin
         checks++;
         assert ((cyc - t0) === 5) else begin
            errors++; $error("FAIL %s_latency got %0d want 5", tag, cyc - t0);
         end
         checks++;
         assert (busy === 1'b1) else begin
            errors++; $error("FAIL %s_busy got %b want 1", tag, busy);
         end
         checks++;
         assert (q.size() > 0) else begin
            errors++; $error("FAIL %s_queue got empty want entry", tag);
         end
         if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            assert (sum === e.s) else begin
               errors++; $error("FAIL %s_sum got %h want %h", tag, sum, e.s);
            end
            checks++;
            assert (flags === e.f) else begin
               errors++; $error("FAIL %s_flags got %b want %b", tag, flags, e.f);
            end
         end
      end
   endtask

   task automatic expect_idle(input string tag);
      int hits;
      hits = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) hits++;
      end
      checks++;
      assert (hits === 0) else begin
         errors++; $error("FAIL %s got %0d active cycles want 0", tag, hits);
      end
   endtask

   initial begin
      reset_n = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      checks++;
      assert ({sum, done, busy, flags} === 38'd0) else begin
         errors++; $error("FAIL reset got %h/%b/%b/%b want 0", sum, done, busy, flags);
      end
      reset_n = 1'b1;

      launch(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000); wait_done("one_plus_two");
      launch(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000); wait_done("x_minus_x");
      launch(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001); wait_done("tie_even");
      launch(32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 4'b0001); wait_done("above_half");
      launch(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101); wait_done("overflow");
      launch(32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000); wait_done("inf_m_inf");
      launch(32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000); wait_done("nan_in");
      launch(32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 4'b0000); wait_done("inf_fin");
      launch(32'h3FC00000, 32'h80000000, 1'b0, 32'h3FC00000, 4'b0000); wait_done("x_plus_0");
      launch(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000); wait_done("neg_zeros");
      launch(32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 4'b0000); wait_done("nz_sub_pz");
      launch(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000); wait_done("three_m_one");
      launch(32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0000); wait_done("neg_result");
      launch(32'h3FFFFFFF, 32'h34000000, 1'b0, 32'h40000000, 4'b0000); wait_done("carry_norm");
      launch(32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 4'b0001); wait_done("round_carry");
`ifdef FPADD_DENORM_EN
      launch(32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 4'b0000); wait_done("sub_add");
      launch(32'h00800001, 32'h00800000, 1'b1, 32'h00000001, 4'b0000); wait_done("tiny_res");
      launch(32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0001); wait_done("sub_norm");
`else
      launch(32'h00000001, 32'h00000001, 1'b0, 32'h00000000, 4'b0000); wait_done("sub_add");
      launch(32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0011); wait_done("tiny_res");
      launch(32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000); wait_done("sub_norm");
`endif

      // start pulsed while busy must not disturb the operation in flight
      launch(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000);
      @(posedge clk);
      #1 a = 32'h7F800000; b = 32'hFF800000; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done("busy_ignore");

      // start in the done cycle is dropped
      a = 32'h40000000; b = 32'h40000000; op = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      expect_idle("done_cycle_start");

      // back-to-back: start in the cycle right after done
      launch(32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 4'b0000); wait_done("b2b_first");
      launch(32'h40400000, 32'h40400000, 1'b0, 32'h40C00000, 4'b0000); wait_done("b2b_second");

      // reset during ALIGN discards the operation
      drive(32'h3F800000, 32'h3F800000, 1'b0);
      @(posedge clk);
      #1 reset_n = 1'b0;
      #1;
      checks++;
      assert ({sum, done, busy, flags} === 38'd0) else begin
         errors++; $error("FAIL mid_reset got %h/%b/%b/%b want 0", sum, done, busy, flags);
      end
      @(negedge clk);
      reset_n = 1'b1;
      expect_idle("mid_reset_no_done");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
